// File: rtl/riscv_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package riscv_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_e;

    // Read data returned to the owner when an access is aborted by the watchdog.
    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEADBEEF;

    localparam int DEF_MAX_DATA_STREAK = 4;
    localparam int DEF_TIMEOUT_CYCLES  = 64;

endpackage

// File: rtl/arb_watchdog.sv
// Loadable up-counter with clear; o_tc flags the counting cycle that reaches TC.
module arb_watchdog
    import riscv_arb_pkg::*;
#(
    parameter int TC    = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W = $clog2(TC + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    // Terminal count: the TC-th enabled cycle since the last load/clear.
    assign o_tc = i_en && (r_cnt == CNT_W'(TC - 1));

    // Counter: clear beats load, load beats increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      r_cnt <= '0;
        else if (i_clr)  r_cnt <= '0;
        else if (i_load) r_cnt <= i_load_val;
        else if (i_en)   r_cnt <= r_cnt + CNT_W'(1);
    end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Arbiter sharing one single-port memory between the fetch port and the MEM-stage
// data port. Data wins ties; a streak counter forces a fetch after MAX_DATA_STREAK
// consecutive data grants while a fetch waits.
// Optional watchdog abort: define RISCV_ARB_TIMEOUT_EN.
module riscv_mem_arbiter
    import riscv_arb_pkg::*;
#(
    parameter int MAX_DATA_STREAK = DEF_MAX_DATA_STREAK,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_valid,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wstrb,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_f,
    output logic        stall_m,
    output logic        arb_err
);

    localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);

    arb_state_e          r_state, w_next;
    arb_owner_e          w_owner;
    logic [STREAK_W-1:0] r_streak;
    logic                w_gnt_i, w_gnt_d;
    logic                w_done, w_tmo, w_end;

    assign w_owner = (r_state == ST_GNT_D) ? OWN_D : OWN_I;
    assign w_done  = (r_state != ST_IDLE) && mem_ack;
    assign w_end   = w_done || w_tmo;
    assign stall_f = if_req && !if_valid;
    assign stall_m = d_req && !d_valid;

`ifdef RISCV_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic w_wd_tc;

    arb_watchdog #(.TC(TIMEOUT_CYCLES), .CNT_W(WD_W)) u_wd (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (w_end),
        .i_load     (w_gnt_i || w_gnt_d),
        .i_load_val ({WD_W{1'b0}}),
        .i_en       ((r_state != ST_IDLE) && !mem_ack),
        .o_tc       (w_wd_tc)
    );

    // An ack in the same cycle as the terminal count completes normally.
    assign w_tmo = w_wd_tc && !mem_ack;
`else
    assign w_tmo = 1'b0;
    // TIMEOUT_CYCLES only sizes the watchdog; keep it referenced in this build.
    if (TIMEOUT_CYCLES < 1) begin : g_no_watchdog
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Arbitration in IDLE and completion back to IDLE.
    always_comb begin
        w_next  = r_state;
        w_gnt_i = 1'b0;
        w_gnt_d = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (d_req && (!if_req || (r_streak < STREAK_W'(MAX_DATA_STREAK)))) begin
                    w_gnt_d = 1'b1;
                    w_next  = ST_GNT_D;
                end else if (if_req) begin
                    w_gnt_i = 1'b1;
                    w_next  = ST_GNT_I;
                end
            end
            ST_GNT_I, ST_GNT_D: if (w_end) w_next = ST_IDLE;
            default:            w_next = ST_IDLE;
        endcase
    end

    // Memory request registers, returned read data and completion pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
            arb_err   <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            arb_err  <= 1'b0;
            if (w_gnt_d) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_wstrb <= d_we ? d_wstrb : 4'b0000;
            end else if (w_gnt_i) begin
                mem_req   <= 1'b1;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                mem_wstrb <= 4'b0000;
            end else if (w_end) begin
                mem_req <= 1'b0;
                arb_err <= w_tmo;
                if (w_owner == OWN_D) begin
                    d_valid <= 1'b1;
                    if (!mem_we) d_rdata <= w_done ? mem_rdata : TIMEOUT_RDATA;
                end else begin
                    if_valid <= 1'b1;
                    if_rdata <= w_done ? mem_rdata : TIMEOUT_RDATA;
                end
            end
        end
    end

    // Consecutive data grants while a fetch waits; any fetch grant or an
    // uncontended data grant restarts the streak.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_streak <= '0;
        end else if (w_gnt_d && if_req) begin
            if (r_streak != STREAK_W'(MAX_DATA_STREAK)) r_streak <= r_streak + STREAK_W'(1);
        end else if (w_gnt_d || w_gnt_i) begin
            r_streak <= '0;
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed self-checking bench for riscv_mem_arbiter.
module tb_riscv_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_wstrb;
    logic        d_valid;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic        stall_f, stall_m, arb_err;

    int checks = 0;
    int errors = 0;

    riscv_mem_arbiter #(.MAX_DATA_STREAK(4), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_f(stall_f), .stall_m(stall_m), .arb_err(arb_err)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; if_req = 0; if_addr = 0; d_req = 0; d_we = 0;
        d_addr = 0; d_wdata = 0; d_wstrb = 0; mem_rdata = 0; mem_ack = 0;
        tick(); tick();
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_wstrb !== 4'h0 || mem_addr !== 32'h0) begin
            errors++; $display("FAIL reset_mem got req=%b we=%b strb=%h addr=%h exp all 0", mem_req, mem_we, mem_wstrb, mem_addr); end
        checks++; if (if_rdata !== 32'h0 || d_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got i=%h d=%h exp 0", if_rdata, d_rdata); end
        checks++; if (if_valid !== 1'b0 || d_valid !== 1'b0 || arb_err !== 1'b0) begin
            errors++; $display("FAIL reset_pulses got iv=%b dv=%b err=%b exp 0", if_valid, d_valid, arb_err); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_fetch();
        if_req = 1; if_addr = 32'h0000_0010;
        #1;
        checks++; if (stall_f !== 1'b1) begin errors++; $display("FAIL fetch_stall_pre got %b exp 1", stall_f); end
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0 || mem_wstrb !== 4'h0) begin
            errors++; $display("FAIL fetch_grant got req=%b addr=%h we=%b strb=%h exp 1/10/0/0", mem_req, mem_addr, mem_we, mem_wstrb); end
        tick(); tick();
        checks++; if (mem_req !== 1'b1 || if_valid !== 1'b0 || stall_f !== 1'b1) begin
            errors++; $display("FAIL fetch_wait got req=%b iv=%b stall=%b exp 1/0/1", mem_req, if_valid, stall_f); end
        mem_ack = 1; mem_rdata = 32'h0050_0093;
        tick();
        checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h0050_0093 || mem_req !== 1'b0) begin
            errors++; $display("FAIL fetch_done got iv=%b rdata=%h req=%b exp 1/00500093/0", if_valid, if_rdata, mem_req); end
        checks++; if (stall_f !== 1'b0) begin errors++; $display("FAIL fetch_stall_done got %b exp 0", stall_f); end
        if_req = 0; mem_ack = 0;
        tick();
        checks++; if (if_valid !== 1'b0 || mem_req !== 1'b0 || d_valid !== 1'b0) begin
            errors++; $display("FAIL fetch_pulse_end got iv=%b req=%b dv=%b exp 0/0/0", if_valid, mem_req, d_valid); end
    endtask

    task automatic test_contention();
        logic [6:0] exp_d;
        int loads;
        exp_d = 7'b1101111;  // bit g: 1 = data grant expected at grant g
        loads = 0;
        if_req = 1; if_addr = 32'h200; d_req = 1; d_we = 0; d_addr = 32'h300; d_wstrb = 4'hF;
        for (int g = 0; g < 7; g++) begin
            tick();
            checks++; if (mem_req !== 1'b1 || mem_addr !== (exp_d[g] ? 32'h300 : 32'h200) || mem_wstrb !== 4'h0) begin
                errors++; $display("FAIL contention_grant%0d got req=%b addr=%h strb=%h exp 1/%h/0", g, mem_req, mem_addr, mem_wstrb, exp_d[g] ? 32'h300 : 32'h200); end
            mem_ack = 1; mem_rdata = 32'hA000_0000 + g;
            tick();
            checks++; if (d_valid !== exp_d[g] || if_valid !== !exp_d[g] || mem_req !== 1'b0) begin
                errors++; $display("FAIL contention_valid%0d got dv=%b iv=%b req=%b exp %b/%b/0", g, d_valid, if_valid, mem_req, exp_d[g], !exp_d[g]); end
            if (exp_d[g]) begin
                checks++; if (d_rdata !== 32'hA000_0000 + g) begin
                    errors++; $display("FAIL contention_drdata%0d got %h exp %h", g, d_rdata, 32'hA000_0000 + g); end
                loads++;
                if (loads == 6) d_req = 0;
            end else begin
                checks++; if (if_rdata !== 32'hA000_0000 + g) begin
                    errors++; $display("FAIL contention_irdata%0d got %h exp %h", g, if_rdata, 32'hA000_0000 + g); end
                if_req = 0;
            end
            mem_ack = 0;
        end
        tick();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL contention_idle got req=%b exp 0", mem_req); end
    endtask

    task automatic test_store();
        d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hCAFE_F00D; d_wstrb = 4'b0011;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hCAFE_F00D || mem_wstrb !== 4'b0011) begin
            errors++; $display("FAIL store_grant got req=%b we=%b addr=%h wd=%h strb=%b exp 1/1/100/cafef00d/0011", mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb); end
        checks++; if (stall_m !== 1'b1) begin errors++; $display("FAIL store_stall got %b exp 1", stall_m); end
        mem_ack = 1; mem_rdata = 32'h1234_5678;
        tick();
        checks++; if (d_valid !== 1'b1 || d_rdata !== 32'hA000_0006 || stall_m !== 1'b0) begin
            errors++; $display("FAIL store_done got dv=%b rdata=%h stall=%b exp 1/a0000006/0", d_valid, d_rdata, stall_m); end
        d_req = 0; d_we = 0; mem_ack = 0;
        tick();
        checks++; if (d_valid !== 1'b0) begin errors++; $display("FAIL store_pulse_end got %b exp 0", d_valid); end
    endtask

    task automatic test_mid_grant_drop();
        d_req = 1; d_we = 0; d_addr = 32'h400; d_wdata = 32'h0; d_wstrb = 4'hF;
        tick();
        d_req = 0; d_addr = 32'h0;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h400) begin
            errors++; $display("FAIL drop_hold got req=%b addr=%h exp 1/400", mem_req, mem_addr); end
        tick();
        mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
        tick();
        checks++; if (d_valid !== 1'b1 || d_rdata !== 32'h0BAD_F00D || mem_req !== 1'b0) begin
            errors++; $display("FAIL drop_done got dv=%b rdata=%h req=%b exp 1/0badf00d/0", d_valid, d_rdata, mem_req); end
        mem_ack = 0;
        tick();
        checks++; if (d_valid !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL drop_after got dv=%b req=%b exp 0/0", d_valid, mem_req); end
    endtask

    task automatic test_reset_mid_access();
        d_req = 1; d_we = 0; d_addr = 32'h500;
        tick(); tick();
        reset = 0;
        #1;
        checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || d_rdata !== 32'h0) begin
            errors++; $display("FAIL rst_mid_async got req=%b addr=%h rdata=%h exp 0/0/0", mem_req, mem_addr, d_rdata); end
        d_req = 0; mem_ack = 1;
        tick();
        reset = 1;
        tick();
        checks++; if (d_valid !== 1'b0 || if_valid !== 1'b0 || mem_req !== 1'b0) begin
            errors++; $display("FAIL rst_mid_idle got dv=%b iv=%b req=%b exp 0/0/0", d_valid, if_valid, mem_req); end
        mem_ack = 0; if_req = 1; if_addr = 32'h0000_0040;
        tick();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
            errors++; $display("FAIL rst_mid_regrant got req=%b addr=%h exp 1/40", mem_req, mem_addr); end
        mem_ack = 1; mem_rdata = 32'h0000_0013;
        tick();
        checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h13) begin
            errors++; $display("FAIL rst_mid_fetch got iv=%b rdata=%h exp 1/13", if_valid, if_rdata); end
        if_req = 0; mem_ack = 0;
        tick();
    endtask

`ifdef RISCV_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        n = 0;
        if_req = 1; if_addr = 32'h600;
        tick();
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (if_valid) begin n = i; break; end
        end
        checks++; if (n !== 8) begin errors++; $display("FAIL timeout_cycles got %0d exp 8", n); end
        checks++; if (if_rdata !== 32'hDEADBEEF || arb_err !== 1'b1 || mem_req !== 1'b0) begin
            errors++; $display("FAIL timeout_abort got rdata=%h err=%b req=%b exp deadbeef/1/0", if_rdata, arb_err, mem_req); end
        if_req = 0;
        tick();
        checks++; if (arb_err !== 1'b0 || if_valid !== 1'b0) begin
            errors++; $display("FAIL timeout_pulse_end got err=%b iv=%b exp 0/0", arb_err, if_valid); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_store();
        test_mid_grant_drop();
        test_reset_mid_access();
`ifdef RISCV_ARB_TIMEOUT_EN
        test_timeout();
`endif
        checks++; if (arb_err !== 1'b0) begin errors++; $display("FAIL arb_err_idle got %b exp 0", arb_err); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
- Shares one single-port unified memory between the pipelined CPU's instruction-fetch port and its MEM-stage data port.
- Owns the memory handshake and a per-access FSM, and returns registered read data to each requester.
- Produces per-port stall signals that the pipeline hazard logic uses to freeze the fetch stage and the MEM stage.
- Data accesses have priority; a streak counter guarantees fetch progress.

Parameters:
- MAX_DATA_STREAK, 4: max consecutive data grants while a fetch is pending; then fetch is forced.
- TIMEOUT_CYCLES, 64: cycles without mem_ack before an access is aborted (only with the optional feature).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; whole block is reset while low
- if_req  in  1  fetch request; held with if_addr until if_valid
- if_addr  in  32  fetch address (PC)
- if_rdata  out  32  fetched instruction
- if_valid  out  1  one-cycle pulse: fetch complete
- d_req  in  1  data request; held with d_* inputs until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_wstrb  in  4  store byte enables
- d_rdata  out  32  load data
- d_valid  out  1  one-cycle pulse: data access complete
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_wstrb  out  4  memory byte enables (0000 on reads)
- mem_rdata  in  32  memory read data, valid with mem_ack
- mem_ack  in  1  memory completes the access this cycle
- stall_f  out  1  if_req & ~if_valid (combinational)
- stall_m  out  1  d_req & ~d_valid (combinational)
- arb_err  out  1  one-cycle pulse on a timeout abort

Behaviour:
- Reset values: state IDLE; all mem_* outputs 0; if_rdata = d_rdata = 0; if_valid = d_valid = arb_err = 0; streak counter 0.
- States: IDLE, GNT_I, GNT_D.
- Arbitration in IDLE:
  - d_req & (~if_req | streak < MAX_DATA_STREAK) → GNT_D.
  - Else if_req → GNT_I.
  - Else stay in IDLE.
- On grant, the requester's address, we, wdata and wstrb are latched into the mem_* registers and mem_req = 1 from the next cycle.
- Latched mem_* values stay stable until ack. A requester dropping req mid-grant does not cancel the access; the access completes and its valid still pulses.
- In GNT_x with mem_ack = 1:
  - mem_req drops next cycle and the state returns to IDLE.
  - On a read, mem_rdata is captured into if_rdata or d_rdata.
  - The matching valid pulses for exactly one cycle, in the cycle after ack.
  - On a store, d_rdata holds its previous value.
- Latency: req sampled in IDLE at cycle N → mem_req high at N+1. With ack at N+k (k ≥ 1), valid is high at N+k+1. Re-arbitration happens at N+k+1; minimum 2 cycles per access, no back-to-back overlap.
- Streak counter:
  - Increments on each GNT_D entry while if_req = 1, saturating at MAX_DATA_STREAK.
  - Clears on GNT_I entry, and on GNT_D entry with if_req = 0.
- Simultaneous: the valid pulse and the new arbitration decision occur in the same cycle. The requester that just completed must deassert or present a new request; a req still high in that cycle is treated as a new access.
- mem_ack while in IDLE is ignored.
- Reset asserted mid-access: immediate return to reset values; the in-flight access is abandoned with no valid pulse.

Optional Feature:
- Macro: RISCV_ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in GNT_x without mem_ack.
  - When the count reaches TIMEOUT_CYCLES, mem_req drops and the state returns to IDLE.
  - The owner's valid pulses with rdata = 32'hDEADBEEF on reads (on stores rdata is unchanged), and arb_err pulses for one cycle.
- Undefined: no watchdog logic; GNT_x waits indefinitely; arb_err is tied to 0.

Decomposition:
- Package riscv_arb_pkg:
  - state encoding (IDLE/GNT_I/GNT_D)
  - owner encoding
  - TIMEOUT_RDATA = 32'hDEADBEEF
  - default MAX_DATA_STREAK and TIMEOUT_CYCLES
- Sub-module arb_watchdog: loadable up-counter with clear and a terminal-count pulse. It is instantiated only under RISCV_ARB_TIMEOUT_EN.

Test Plan:
- Single fetch: if_req = 1, if_addr = 0x0000_0010, ack after 3 cycles with mem_rdata = 0x0050_0093 → if_rdata = 0x0050_0093; if_valid pulses 1 cycle; stall_f is high until that pulse.
- Store: d_req = 1, d_we = 1, d_addr = 0x100, d_wdata = 0xCAFE_F00D, d_wstrb = 0011 → mem_wstrb = 0011, mem_we = 1; d_valid pulses; d_rdata unchanged.
- Contention: if_req and d_req high together, MAX_DATA_STREAK = 4, data requester issues 6 loads → grant order D, D, D, D, I, D, D.
- Mid-grant drop: d_req deasserted 1 cycle after grant → mem_req stays high until ack; d_valid still pulses.
- Reset mid-access: reset low during GNT_D before ack → mem_req = 0 immediately; no valid pulse; state IDLE after release.
- With RISCV_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 8, no ack on a fetch → after 8 cycles if_valid pulses with if_rdata = 0xDEADBEEF, and arb_err pulses once.
